lsu: RTL and testbench
======================

# lsu

Load/store unit in the execute→write-back path of the NPC core. Consumes the ALU result as an effective address, or as a pass-through value for non-memory instructions. Runs one data-memory transaction per instruction over a valid/ready memory port, and returns a write-back value to the WBU. Handles byte/half/word lane steering, store masks and load sign/zero extension.

## Interface
- `XLEN`, default 32: datapath width. Only 32 is supported.
- `TIMEOUT_CYCLES`, default 255: maximum cycles in WAIT before raising `out_err`. A value of 0 disables the timeout.

- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset. Sampled on the `clk` rising edge.
- `in_valid` in 1: EXU request valid.
- `in_ready` out 1: LSU can accept a request.
- `in_addr` in XLEN: ALU result (effective address or pass-through value).
- `in_wdata` in XLEN: rs2 store data.
- `in_memop` in 3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- `in_memrd` in 1: load.
- `in_memwr` in 1: store. Takes priority when both `in_memrd` and `in_memwr` are set.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_addr` out XLEN: word-aligned address, `{in_addr[XLEN-1:2], 2'b00}`.
- `mem_wen` out 1: 1 = write.
- `mem_wdata` out XLEN: lane-replicated store data.
- `mem_wmask` out 4: byte enables. 0 for reads.
- `mem_rsp_valid` in 1: read data or write acknowledge.
- `mem_rdata` in XLEN: read word.
- `out_valid` out 1: write-back value valid.
- `out_ready` in 1: WBU accepts the value.
- `out_data` out XLEN: loaded/extended data, or the pass-through value.
- `out_err` out 1: misaligned access or timeout. Qualified by `out_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: `in_ready`=1. On `in_valid`, capture addr, wdata, memop, rd and wr.
  - Neither rd nor wr: go to DONE with `out_data`=`in_addr`.
  - Otherwise: go to REQ, or to DONE with `out_err`=1 if misaligned (see Configuration).
- REQ: `mem_req_valid`=1, all `mem_*` outputs held stable. On `mem_req_ready` go to WAIT.
- WAIT: on `mem_rsp_valid` latch the extended read data (loads) or 0 (stores), then go to DONE. Responses are sampled only in WAIT.
- DONE: `out_valid`=1. On `out_ready` go to IDLE.
- Store steering, with `off`=`addr[1:0]`:
  - sb: `mem_wdata`={4{wdata[7:0]}}, `mem_wmask`=4'b0001<<off.
  - sh: `mem_wdata`={2{wdata[15:0]}}, `mem_wmask`=4'b0011<<off.
  - sw: `mem_wdata`=wdata, `mem_wmask`=4'b1111.
- Load extraction:
  - `sh`=`mem_rdata`>>(8*off).
  - lb/lbu sign- or zero-extend `sh[7:0]`.
  - lh/lhu sign- or zero-extend `sh[15:0]`.
  - lw returns `mem_rdata` unchanged.
- Timeout: an 8+-bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches `TIMEOUT_CYCLES`, go to DONE with `out_err`=1 and `out_data`=0. A late response is then ignored.
- Reserved `in_memop` codes (011, 11x) with rd/wr set behave as lw/sw.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 after. `mem_req_valid`=0, `mem_wen`=0, `mem_wmask`=0, `out_valid`=0, `out_err`=0, `out_data`=0. State = IDLE, counter = 0.
- `rst` in any state returns to IDLE next edge and drops `mem_req_valid` immediately. The pending transaction is discarded.
- Minimum memory latency, accept at edge N:
  - `mem_req_valid` high in cycle N+1.
  - With `mem_req_ready`=1 in N+1 and `mem_rsp_valid` in N+2, `out_valid` is high in N+3.
- Pass-through or misaligned requests: accepted at N, `out_valid` high at N+1.
- Throughput is one request per transaction. `in_ready` is low in REQ, WAIT and DONE.
- `out_data` and `out_err` stay stable while `out_valid`=1 and `out_ready`=0.
- `mem_req_valid` never drops before `mem_req_ready`.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - lh/lhu/sh with `addr[0]`=1, or lw/sw with `addr[1:0]`≠0, issues no memory request.
  - Goes to DONE with `out_err`=1 and `out_data`=0.
- Undefined:
  - No check is performed.
  - Half accesses treat `addr[0]` as 0. Word accesses treat `addr[1:0]` as 0.
  - `out_err` is driven only by the timeout.

## Test plan
- sw addr=0x8000_0004, wdata=0xDEADBEEF, memory ready/responds in 1 cycle → `mem_addr`=0x8000_0004, `mem_wmask`=1111, `mem_wen`=1. `out_valid` at N+3, `out_data`=0, `out_err`=0.
- lb addr=0x8000_0003, `mem_rdata`=0x80FF_0102 → `out_data`=0xFFFF_FF80. lbu at the same address → 0x0000_0080.
- sh addr=0x8000_0002, wdata=0x1234_ABCD → `mem_wdata`=0xABCD_ABCD, `mem_wmask`=1100.
- Pass-through: memrd=memwr=0, addr=0x0000_0042 → `out_valid` at N+1, `out_data`=0x42, no `mem_req_valid`. Hold `out_ready`=0 for 3 cycles → `out_data` stable.
- With `LSU_MISALIGN_CHECK_EN`: lw addr=0x8000_0001 → `out_err`=1 at N+1, no memory request. Without it → request to 0x8000_0000 with full word read.
- `TIMEOUT_CYCLES`=4, memory never responds → `out_err`=1 after 4 WAIT cycles. Assert `rst` during REQ → `mem_req_valid`=0 next cycle, `in_ready`=1 after.

Source files
------------

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load/store unit between execute and write-back. Takes the ALU
//             result as an effective address (or pass-through value), runs a
//             single data-memory transaction over a valid/ready port, and
//             returns the write-back value with lane steering, store masks
//             and load sign/zero extension applied.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_*                - request from EXU (valid/ready handshake)
//             mem_req_*, mem_*    - word-aligned memory request channel
//             mem_rsp_valid/rdata - memory response (read data or write ack)
//             out_*               - write-back value to WBU (valid/ready)
//  Params   : XLEN (32 only), TIMEOUT_CYCLES (0 disables the WAIT timeout)
//  Options  : LSU_MISALIGN_CHECK_EN - reject misaligned half/word accesses
//                                     with out_err instead of masking offsets
//  Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [2:0]      in_memop,
    input  logic            in_memrd,
    input  logic            in_memwr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_err
);

    // Counter is at least 8 bits, wider only if the timeout needs it.
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);
    localparam logic c_to_en = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_req  = 2'd1;
    localparam logic [1:0] c_wait = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [2:0]         r_memop;
    logic               r_wr;
    logic [XLEN-1:0]    r_out_data;
    logic               r_out_err;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_in_mem;
    logic               w_in_misalign;
    logic               w_timeout;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               w_is_byte;
    logic               w_is_half;
    logic [1:0]         w_off;
    logic [XLEN-1:0]    w_store_data;
    logic [3:0]         w_store_mask;
    logic [XLEN-1:0]    w_shifted;
    logic [XLEN-1:0]    w_load_data;
    logic               w_sext;
    logic               w_req_active;

    assign w_in_mem = in_memrd | in_memwr;

`ifdef LSU_MISALIGN_CHECK_EN
    // Codes 01 are halves; any code with bit 1 set is a word (reserved codes included).
    assign w_in_misalign = ((in_memop[1:0] == 2'b01) && in_addr[0]) ||
                           (in_memop[1] && (in_addr[1:0] != 2'b00));
`else
    assign w_in_misalign = 1'b0;
`endif

    assign w_cnt_inc = r_cnt + c_cnt_w'(1);
    assign w_timeout = c_to_en && (w_cnt_inc == c_timeout);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (in_valid) begin
                    if (!w_in_mem || w_in_misalign) begin
                        w_state_nxt = c_done;
                    end else begin
                        w_state_nxt = c_req;
                    end
                end
            end
            c_req: begin
                if (mem_req_ready) begin
                    w_state_nxt = c_wait;
                end
            end
            c_wait: begin
                if (mem_rsp_valid || w_timeout) begin
                    w_state_nxt = c_done;
                end
            end
            c_done: begin
                if (out_ready) begin
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, timeout counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_memop    <= 3'b000;
            r_wr       <= 1'b0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_addr  <= in_addr;
                        r_wdata <= in_wdata;
                        r_memop <= in_memop;
                        r_wr    <= in_memwr;
                        if (!w_in_mem) begin
                            r_out_data <= in_addr;
                            r_out_err  <= 1'b0;
                        end else if (w_in_misalign) begin
                            r_out_data <= '0;
                            r_out_err  <= 1'b1;
                        end
                    end
                end
                c_req: begin
                    if (mem_req_ready) begin
                        r_cnt <= '0;
                    end
                end
                c_wait: begin
                    // A response in the final WAIT cycle wins over the timeout.
                    if (mem_rsp_valid) begin
                        r_out_data <= r_wr ? '0 : w_load_data;
                        r_out_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_out_data <= '0;
                        r_out_err  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Lane steering. Offsets finer than the access size are ignored, so
    // half accesses use addr[1] only and word accesses use no offset.
    // ------------------------------------------------------------------
    always_comb begin
        w_is_byte = (r_memop[1:0] == 2'b00);
        w_is_half = (r_memop[1:0] == 2'b01);
        w_sext    = ~r_memop[2];
        if (w_is_byte) begin
            w_off = r_addr[1:0];
        end else if (w_is_half) begin
            w_off = {r_addr[1], 1'b0};
        end else begin
            w_off = 2'b00;
        end

        if (w_is_byte) begin
            w_store_data = {4{r_wdata[7:0]}};
            w_store_mask = 4'b0001 << w_off;
        end else if (w_is_half) begin
            w_store_data = {2{r_wdata[15:0]}};
            w_store_mask = 4'b0011 << w_off;
        end else begin
            w_store_data = r_wdata;
            w_store_mask = 4'b1111;
        end

        w_shifted = mem_rdata >> {w_off, 3'b000};
        if (w_is_byte) begin
            w_load_data = {{(XLEN-8){w_sext & w_shifted[7]}}, w_shifted[7:0]};
        end else if (w_is_half) begin
            w_load_data = {{(XLEN-16){w_sext & w_shifted[15]}}, w_shifted[15:0]};
        end else begin
            w_load_data = mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Reset gates the handshakes combinationally so a pending
    // request disappears in the reset cycle itself.
    // ------------------------------------------------------------------
    assign w_req_active  = (r_state == c_req) && !rst;
    assign in_ready      = (r_state == c_idle) && !rst;
    assign mem_req_valid = w_req_active;
    assign mem_addr      = {r_addr[XLEN-1:2], 2'b00};
    assign mem_wen       = w_req_active & r_wr;
    assign mem_wdata     = w_store_data;
    assign mem_wmask     = mem_wen ? w_store_mask : 4'b0000;
    assign out_valid     = (r_state == c_done) && !rst;
    assign out_data      = r_out_data;
    assign out_err       = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Self-checking bench for lsu. A table of request records is
//             applied one at a time; expected write-back values go into a
//             scoreboard queue at acceptance and are popped when out_valid
//             appears. Reset behaviour is exercised by hand-written sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [2:0]  in_memop;
    logic        in_memrd;
    logic        in_memwr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    always #5 clk = ~clk;

    lsu #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_memop      (in_memop),
        .in_memrd      (in_memrd),
        .in_memwr      (in_memwr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_err       (out_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
        logic        rd;
        logic        wr;
        logic [31:0] rdata;
        logic        respond;
        logic        exp_req;
        logic [31:0] exp_maddr;
        logic        exp_wen;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(
        input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] op,
        input logic rd, input logic wr, input logic [31:0] rdata, input logic respond,
        input logic exp_req, input logic [31:0] exp_maddr, input logic exp_wen,
        input logic [3:0] exp_wmask, input logic [31:0] exp_wdata,
        input logic [31:0] exp_data, input logic exp_err, input int exp_lat, input int hold);
        vec_t v;
        v.addr = addr;       v.wdata = wdata;         v.op = op;
        v.rd = rd;           v.wr = wr;               v.rdata = rdata;
        v.respond = respond; v.exp_req = exp_req;     v.exp_maddr = exp_maddr;
        v.exp_wen = exp_wen; v.exp_wmask = exp_wmask; v.exp_wdata = exp_wdata;
        v.exp_data = exp_data; v.exp_err = exp_err;   v.exp_lat = exp_lat;
        v.hold = hold;
        return v;
    endfunction

    // Drives one request, plays a single-cycle memory, and checks the result.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        int   lat;
        logic got;
        logic seen;
        logic rsp_next;
        chk($sformatf("v%0d in_ready_idle", idx), 32'(in_ready), 32'd1);
        in_addr  = v.addr;
        in_wdata = v.wdata;
        in_memop = v.op;
        in_memrd = v.rd;
        in_memwr = v.wr;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.data = v.exp_data;
        e.err  = v.exp_err;
        exp_q.push_back(e);
        got = 1'b0; seen = 1'b0; rsp_next = 1'b0; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid) begin
                got = 1'b1;
                lat = k;
                break;
            end
            mem_rsp_valid = rsp_next & v.respond;
            mem_rdata     = v.rdata;
            rsp_next      = 1'b0;
            if (mem_req_valid) begin
                if (!seen) begin
                    chk($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_maddr);
                    chk($sformatf("v%0d mem_wen", idx), 32'(mem_wen), 32'(v.exp_wen));
                    chk($sformatf("v%0d mem_wmask", idx), 32'(mem_wmask), 32'(v.exp_wmask));
                    if (v.exp_wen)
                        chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
                end
                seen          = 1'b1;
                mem_req_ready = 1'b1;
                rsp_next      = 1'b1;
            end else begin
                mem_req_ready = 1'b0;
            end
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
        end
        chk($sformatf("v%0d out_valid_seen", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d mem_req_issued", idx), 32'(seen), 32'(v.exp_req));
        if (got) begin
            chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
            e = exp_q.pop_front();
            chk($sformatf("v%0d out_data", idx), out_data, e.data);
            chk($sformatf("v%0d out_err", idx), 32'(out_err), 32'(e.err));
            for (int h = 0; h < v.hold; h++) begin
                @(posedge clk); #1;
                chk($sformatf("v%0d hold_valid", idx), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d hold_data", idx), out_data, e.data);
                chk($sformatf("v%0d hold_err", idx), 32'(out_err), 32'(e.err));
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk($sformatf("v%0d out_valid_after", idx), 32'(out_valid), 32'd0);
            chk($sformatf("v%0d in_ready_after", idx), 32'(in_ready), 32'd1);
        end else begin
            exp_q.delete();
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: actual=expired required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_memop = 3'b000;
        in_memrd = 1'b0; in_memwr = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rdata = '0; out_ready = 1'b0;

        //            addr          wdata         op      rd    wr    rdata         rsp   req   maddr         wen   wmask    mwdata        data          err   lat hold
        vecs.push_back(mk(32'h8000_0004, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 32'h8000_0004, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 3, 0));
        vecs.push_back(mk(32'h8000_0003, 32'h0,         3'b000, 1'b1, 1'b0, 32'h80FF_0102, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 3, 0));
        vecs.push_back(mk(32'h8000_0003, 32'h0,         3'b100, 1'b1, 1'b0, 32'h80FF_0102, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 3, 0));
        vecs.push_back(mk(32'h8000_0002, 32'h1234_ABCD, 3'b001, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 32'h8000_0000, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 3, 0));
        vecs.push_back(mk(32'h0000_0042, 32'h0,         3'b000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,        32'h0000_0042, 1'b0, 1, 3));
        vecs.push_back(mk(32'h8000_0002, 32'h0,         3'b001, 1'b1, 1'b0, 32'h80FF_0102, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'hFFFF_80FF, 1'b0, 3, 0));
        vecs.push_back(mk(32'h8000_0000, 32'h0,         3'b101, 1'b1, 1'b0, 32'h80FF_8102, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h0000_8102, 1'b0, 3, 0));
        vecs.push_back(mk(32'h8000_0001, 32'h0000_00A5, 3'b000, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 32'h8000_0000, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0, 3, 0));
        vecs.push_back(mk(32'h8000_0008, 32'h0,         3'b010, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 32'h8000_0008, 1'b0, 4'b0000, 32'h0,        32'h1234_5678, 1'b0, 3, 0));
        vecs.push_back(mk(32'h8000_0001, 32'h0,         3'b000, 1'b1, 1'b0, 32'h80FF_0102, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h0000_0001, 1'b0, 3, 0));
        vecs.push_back(mk(32'h8000_000C, 32'h0,         3'b011, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h8000_000C, 1'b0, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0, 3, 0));
        vecs.push_back(mk(32'h0000_0010, 32'h55AA_55AA, 3'b010, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 4'b1111, 32'h55AA_55AA, 32'h0,        1'b0, 3, 0));
        vecs.push_back(mk(32'h8000_0000, 32'h0,         3'b010, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 6, 1));
`ifdef LSU_MISALIGN_CHECK_EN
        vecs.push_back(mk(32'h8000_0001, 32'h0,         3'b010, 1'b1, 1'b0, 32'h1122_3344, 1'b1, 1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1, 0));
`else
        vecs.push_back(mk(32'h8000_0001, 32'h0,         3'b010, 1'b1, 1'b0, 32'h1122_3344, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h1122_3344, 1'b0, 3, 0));
`endif

        // Reset cycle values
        @(posedge clk); #1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst mem_wen", 32'(mem_wen), 32'd0);
        chk("rst mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_err", 32'(out_err), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset while a request is outstanding in REQ
        in_addr = 32'h8000_0020; in_memop = 3'b010; in_memrd = 1'b1; in_memwr = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rstreq req_valid_before", 32'(mem_req_valid), 32'd1);
        chk("rstreq in_ready_busy", 32'(in_ready), 32'd0);
        rst = 1'b1; #1;
        chk("rstreq req_valid_dropped", 32'(mem_req_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("rstreq req_valid_after", 32'(mem_req_valid), 32'd0);
        chk("rstreq in_ready_after", 32'(in_ready), 32'd1);
        chk("rstreq out_valid_after", 32'(out_valid), 32'd0);

        // Unit still works after the aborted transaction
        apply(vecs[0], 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
